// File: rtl/fpu_operand_unpacker_pkg.sv
// Shared types for the FPU operand unpacker: one-hot operand class,
// NaN propagation source, and binary32 field constants.
package fpu_class;

   typedef enum logic [5:0] {
      ZERO      = 6'b000001,
      SUBNORMAL = 6'b000010,
      NORMAL    = 6'b000100,
      INF       = 6'b001000,
      QNAN      = 6'b010000,
      SNAN      = 6'b100000
   } operand_class_e;

   // A_QUIET / B_QUIET: result stage forces fraction bit 22 to 1
   typedef enum logic [2:0] {
      NONE    = 3'd0,
      A       = 3'd1,
      B       = 3'd2,
      A_QUIET = 3'd3,
      B_QUIET = 3'd4
   } nan_source_e;

   localparam logic [7:0] EXP_MAX  = 8'hFF;
   localparam int         QNAN_BIT = 22;

endpackage

// File: rtl/fpu_operand_unpacker_classifier.sv
// Combinational unpack/classify of one binary32 operand.
// Ports: op (raw) -> sign, exponent, fraction (hidden bit at [23]), cls.
// FPU_DAZ_EN: subnormals are flushed to signed zero.
module fpu_operand_classifier
   import fpu_class::*;
(
   input  logic [31:0]    op,
   output logic           sign,
   output logic [7:0]     exponent,
   output logic [23:0]    fraction,
   output operand_class_e cls
);

   logic [7:0]  raw_exp;
   logic [22:0] raw_frac;
   logic        exp_zero;
   logic        exp_max;
   logic        frac_zero;

   assign raw_exp   = op[30:23];
   assign raw_frac  = op[22:0];
   assign exp_zero  = (raw_exp == 8'h00);
   assign exp_max   = (raw_exp == EXP_MAX);
   assign frac_zero = (raw_frac == 23'd0);

   always_comb begin
      sign     = op[31];
      exponent = raw_exp;
      fraction = {1'b1, raw_frac};
      cls      = NORMAL;
      if (exp_zero) begin
         if (frac_zero) begin
            cls      = ZERO;
            fraction = 24'd0;
         end else begin
`ifdef FPU_DAZ_EN
            cls      = ZERO;
            fraction = 24'd0;
            exponent = 8'h00;
`else
            // subnormals share the minimum normal scale 2^-126
            cls      = SUBNORMAL;
            fraction = {1'b0, raw_frac};
            exponent = 8'h01;
`endif
         end
      end else if (exp_max) begin
         if (frac_zero)
            cls = INF;
         else if (raw_frac[QNAN_BIT])
            cls = QNAN;
         else
            cls = SNAN;
      end
   end

endmodule

// File: rtl/fpu_operand_unpacker.sv
// Two-stage valid/ready operand unpacker for a binary32 FPU pair.
// Ports: in_valid/in_ready/in_a/in_b in; out_valid/out_ready, per-operand
// sign/exponent/fraction/class, nan_source, invalid out. Macro: FPU_DAZ_EN.
module fpu_operand_unpacker
   import fpu_class::*;
(
   input  logic           clk,
   input  logic           reset_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [31:0]    in_a,
   input  logic [31:0]    in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           sign_a,
   output logic           sign_b,
   output logic [7:0]     exponent_a,
   output logic [7:0]     exponent_b,
   output logic [23:0]    fraction_a,
   output logic [23:0]    fraction_b,
   output operand_class_e class_a,
   output operand_class_e class_b,
   output nan_source_e    nan_source,
   output logic           invalid
);

   logic           s1_valid_q, s1_valid_d;
   logic [31:0]    s1_a_q, s1_a_d;
   logic [31:0]    s1_b_q, s1_b_d;

   logic           s2_valid_q, s2_valid_d;
   logic           sign_a_q, sign_a_d;
   logic           sign_b_q, sign_b_d;
   logic [7:0]     exp_a_q, exp_a_d;
   logic [7:0]     exp_b_q, exp_b_d;
   logic [23:0]    frac_a_q, frac_a_d;
   logic [23:0]    frac_b_q, frac_b_d;
   operand_class_e cls_a_q, cls_a_d;
   operand_class_e cls_b_q, cls_b_d;
   nan_source_e    nsrc_q, nsrc_d;
   logic           inv_q, inv_d;

   logic           u_sign_a, u_sign_b;
   logic [7:0]     u_exp_a, u_exp_b;
   logic [23:0]    u_frac_a, u_frac_b;
   operand_class_e u_cls_a, u_cls_b;
   nan_source_e    u_nsrc;

   logic           s2_advance;
   logic           in_fire;
   logic           s2_load;

   assign s2_advance = !s2_valid_q || out_ready;
   assign in_ready   = !s1_valid_q || s2_advance;
   assign in_fire    = in_valid && in_ready;
   assign s2_load    = s2_advance && s1_valid_q;

   fpu_operand_classifier u_cls_a_i (
      .op       (s1_a_q),
      .sign     (u_sign_a),
      .exponent (u_exp_a),
      .fraction (u_frac_a),
      .cls      (u_cls_a)
   );

   fpu_operand_classifier u_cls_b_i (
      .op       (s1_b_q),
      .sign     (u_sign_b),
      .exponent (u_exp_b),
      .fraction (u_frac_b),
      .cls      (u_cls_b)
   );

   // signaling NaNs outrank quiet ones; A outranks B within a kind
   always_comb begin
      u_nsrc = NONE;
      if (u_cls_a == SNAN)
         u_nsrc = A_QUIET;
      else if (u_cls_b == SNAN)
         u_nsrc = B_QUIET;
      else if (u_cls_a == QNAN)
         u_nsrc = A;
      else if (u_cls_b == QNAN)
         u_nsrc = B;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_a_d     = in_a;
         s1_b_d     = in_b;
      end else if (s2_advance) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      exp_a_d    = exp_a_q;
      exp_b_d    = exp_b_q;
      frac_a_d   = frac_a_q;
      frac_b_d   = frac_b_q;
      cls_a_d    = cls_a_q;
      cls_b_d    = cls_b_q;
      nsrc_d     = nsrc_q;
      inv_d      = inv_q;
      if (s2_advance)
         s2_valid_d = s1_valid_q;
      if (s2_load) begin
         sign_a_d = u_sign_a;
         sign_b_d = u_sign_b;
         exp_a_d  = u_exp_a;
         exp_b_d  = u_exp_b;
         frac_a_d = u_frac_a;
         frac_b_d = u_frac_b;
         cls_a_d  = u_cls_a;
         cls_b_d  = u_cls_b;
         nsrc_d   = u_nsrc;
         inv_d    = (u_cls_a == SNAN) || (u_cls_b == SNAN);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= 32'd0;
         s1_b_q     <= 32'd0;
         s2_valid_q <= 1'b0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         exp_a_q    <= 8'd0;
         exp_b_q    <= 8'd0;
         frac_a_q   <= 24'd0;
         frac_b_q   <= 24'd0;
         cls_a_q    <= ZERO;
         cls_b_q    <= ZERO;
         nsrc_q     <= NONE;
         inv_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         exp_a_q    <= exp_a_d;
         exp_b_q    <= exp_b_d;
         frac_a_q   <= frac_a_d;
         frac_b_q   <= frac_b_d;
         cls_a_q    <= cls_a_d;
         cls_b_q    <= cls_b_d;
         nsrc_q     <= nsrc_d;
         inv_q      <= inv_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign sign_a     = sign_a_q;
   assign sign_b     = sign_b_q;
   assign exponent_a = exp_a_q;
   assign exponent_b = exp_b_q;
   assign fraction_a = frac_a_q;
   assign fraction_b = frac_b_q;
   assign class_a    = cls_a_q;
   assign class_b    = cls_b_q;
   assign nan_source = nsrc_q;
   assign invalid    = inv_q;

endmodule

// File: tb/tb_fpu_operand_unpacker.sv
// Self-checking bench for fpu_operand_unpacker: directed vector table,
// backpressure/reset sequences and randomized scoreboard traffic.
module tb_fpu_operand_unpacker;
   import fpu_class::*;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           in_valid;
   logic           in_ready;
   logic [31:0]    in_a, in_b;
   logic           out_valid;
   logic           out_ready;
   logic           sign_a, sign_b;
   logic [7:0]     exponent_a, exponent_b;
   logic [23:0]    fraction_a, fraction_b;
   operand_class_e class_a, class_b;
   nan_source_e    nan_source;
   logic           invalid;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fpu_operand_unpacker dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sign_a     (sign_a),
      .sign_b     (sign_b),
      .exponent_a (exponent_a),
      .exponent_b (exponent_b),
      .fraction_a (fraction_a),
      .fraction_b (fraction_b),
      .class_a    (class_a),
      .class_b    (class_b),
      .nan_source (nan_source),
      .invalid    (invalid)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic           s;
      logic [7:0]     e;
      logic [23:0]    f;
      operand_class_e c;
   } unp_t;

   // Reference: decode by field value ranges
   function automatic unp_t model(input logic [31:0] x);
      unp_t r;
      int unsigned e;
      int unsigned f;
      e   = (x >> 23) % 256;
      f   = x % (1 << 23);
      r.s = x[31];
      r.e = 8'(e);
      r.f = 24'(f + (1 << 23));
      if (e == 0 && f == 0) begin
         r.c = ZERO; r.f = 0;
      end else if (e == 0) begin
`ifdef FPU_DAZ_EN
         r.c = ZERO; r.f = 0; r.e = 0;
`else
         r.c = SUBNORMAL; r.f = 24'(f); r.e = 1;
`endif
      end else if (e == 255 && f == 0)
         r.c = INF;
      else if (e == 255 && f >= (1 << 22))
         r.c = QNAN;
      else if (e == 255)
         r.c = SNAN;
      else
         r.c = NORMAL;
      return r;
   endfunction

   function automatic nan_source_e model_ns(input operand_class_e ca,
                                            input operand_class_e cb);
      if (ca == SNAN) return A_QUIET;
      if (cb == SNAN) return B_QUIET;
      if (ca == QNAN) return A;
      if (cb == QNAN) return B;
      return NONE;
   endfunction

   task automatic chk_pair(input string tag, input logic [31:0] a,
                           input logic [31:0] b);
      unp_t ma, mb;
      ma = model(a);
      mb = model(b);
      chk({tag, ".sign_a"}, 32'(sign_a), 32'(ma.s));
      chk({tag, ".exp_a"}, 32'(exponent_a), 32'(ma.e));
      chk({tag, ".frac_a"}, 32'(fraction_a), 32'(ma.f));
      chk({tag, ".class_a"}, 32'(class_a), 32'(ma.c));
      chk({tag, ".sign_b"}, 32'(sign_b), 32'(mb.s));
      chk({tag, ".exp_b"}, 32'(exponent_b), 32'(mb.e));
      chk({tag, ".frac_b"}, 32'(fraction_b), 32'(mb.f));
      chk({tag, ".class_b"}, 32'(class_b), 32'(mb.c));
      chk({tag, ".nsrc"}, 32'(nan_source), 32'(model_ns(ma.c, mb.c)));
      chk({tag, ".invalid"}, 32'(invalid),
          32'(ma.c == SNAN || mb.c == SNAN));
   endtask

   typedef struct {
      logic [31:0]    a, b;
      logic           sa;
      operand_class_e ca;
      logic [7:0]     ea;
      logic [23:0]    fa;
      operand_class_e cb;
      logic           sb;
      logic [7:0]     eb;
      logic [23:0]    fb;
      nan_source_e    ns;
      logic           inv;
   } vec_t;

   vec_t vt[8];

   function automatic logic [31:0] rnd_op();
      logic [31:0] x;
      logic [7:0]  e;
      logic [22:0] f;
      case ($urandom_range(0, 5))
         0: e = 8'h00;
         1, 2: e = 8'hFF;
         default: e = 8'($urandom_range(1, 254));
      endcase
      case ($urandom_range(0, 4))
         0: f = 23'd0;
         1: f = 23'h400000;
         2: f = 23'($urandom_range(1, 3));
         default: f = 23'($urandom);
      endcase
      x = {1'($urandom), e, f};
      return x;
   endfunction

   logic [31:0] qa[$], qb[$];
   logic [31:0] ba[4];
   int sent, got;
   bit ok;

   initial begin
      reset_n = 0; in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;

      vt[0] = '{32'h3F800000, 32'hC0000000, 0, NORMAL, 8'h7F, 24'h800000,
                NORMAL, 1, 8'h80, 24'h800000, NONE, 0};
      vt[1] = '{32'h7FC00000, 32'h7FA00000, 0, QNAN, 8'hFF, 24'hC00000,
                SNAN, 0, 8'hFF, 24'hA00000, B_QUIET, 1};
`ifdef FPU_DAZ_EN
      vt[2] = '{32'h00000001, 32'h00000000, 0, ZERO, 8'h00, 24'h000000,
                ZERO, 0, 8'h00, 24'h000000, NONE, 0};
      vt[7] = '{32'h807FFFFF, 32'h00800000, 1, ZERO, 8'h00, 24'h000000,
                NORMAL, 0, 8'h01, 24'h800000, NONE, 0};
`else
      vt[2] = '{32'h00000001, 32'h00000000, 0, SUBNORMAL, 8'h01, 24'h000001,
                ZERO, 0, 8'h00, 24'h000000, NONE, 0};
      vt[7] = '{32'h807FFFFF, 32'h00800000, 1, SUBNORMAL, 8'h01, 24'h7FFFFF,
                NORMAL, 0, 8'h01, 24'h800000, NONE, 0};
`endif
      vt[3] = '{32'h7F800000, 32'hFF800000, 0, INF, 8'hFF, 24'h800000,
                INF, 1, 8'hFF, 24'h800000, NONE, 0};
      vt[4] = '{32'h7F800001, 32'h7FC00000, 0, SNAN, 8'hFF, 24'h800001,
                QNAN, 0, 8'hFF, 24'hC00000, A_QUIET, 1};
      vt[5] = '{32'h7FC00001, 32'h3F800000, 0, QNAN, 8'hFF, 24'hC00001,
                NORMAL, 0, 8'h7F, 24'h800000, A, 0};
      vt[6] = '{32'h80000000, 32'h7FFFFFFF, 1, ZERO, 8'h00, 24'h000000,
                QNAN, 0, 8'hFF, 24'hFFFFFF, B, 0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1;
      #1;
      chk("rst.out_valid", 32'(out_valid), 0);
      chk("rst.in_ready", 32'(in_ready), 1);
      chk("rst.class_a", 32'(class_a), 32'(ZERO));
      chk("rst.class_b", 32'(class_b), 32'(ZERO));
      chk("rst.nsrc", 32'(nan_source), 32'(NONE));
      chk("rst.invalid", 32'(invalid), 0);
      chk("rst.frac_a", 32'(fraction_a), 0);

      // directed table
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1; in_a = vt[i].a; in_b = vt[i].b; out_ready = 1;
         #1 chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 1);
         @(negedge clk);
         in_valid = 0;
         chk($sformatf("v%0d.early", i), 32'(out_valid), 0);
         @(negedge clk);
         chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 1);
         chk($sformatf("v%0d.sign_a", i), 32'(sign_a), 32'(vt[i].sa));
         chk($sformatf("v%0d.class_a", i), 32'(class_a), 32'(vt[i].ca));
         chk($sformatf("v%0d.exp_a", i), 32'(exponent_a), 32'(vt[i].ea));
         chk($sformatf("v%0d.frac_a", i), 32'(fraction_a), 32'(vt[i].fa));
         chk($sformatf("v%0d.class_b", i), 32'(class_b), 32'(vt[i].cb));
         chk($sformatf("v%0d.sign_b", i), 32'(sign_b), 32'(vt[i].sb));
         chk($sformatf("v%0d.exp_b", i), 32'(exponent_b), 32'(vt[i].eb));
         chk($sformatf("v%0d.frac_b", i), 32'(fraction_b), 32'(vt[i].fb));
         chk($sformatf("v%0d.nsrc", i), 32'(nan_source), 32'(vt[i].ns));
         chk($sformatf("v%0d.invalid", i), 32'(invalid), 32'(vt[i].inv));
      end
      @(negedge clk);

      // backpressure: 4 pairs, out_ready low first
      for (int k = 0; k < 4; k++)
         ba[k] = {1'b0, 8'(10 + k), 23'(k + 1)};
      sent = 0; got = 0; out_ready = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         in_valid = 1; in_a = ba[sent]; in_b = 32'h0;
         #1;
         if (c == 5) begin
            chk("bp.hold_valid", 32'(out_valid), 1);
            chk("bp.hold_exp", 32'(exponent_a), 32'd10);
            chk("bp.hold_frac", 32'(fraction_a), 32'h800001);
         end
         if (in_ready) sent++;
      end
      chk("bp.accepts", 32'(sent), 2);
      for (int c = 0; c < 20 && got < 4; c++) begin
         @(negedge clk);
         out_ready = 1;
         in_valid = (sent < 4);
         in_a = ba[sent % 4];
         #1;
         if (out_valid) begin
            chk($sformatf("bp.exp%0d", got), 32'(exponent_a), 32'(10 + got));
            chk($sformatf("bp.frac%0d", got), 32'(fraction_a),
                32'h800000 + 32'(got + 1));
            got++;
         end
         if (in_valid && in_ready) sent++;
      end
      chk("bp.received", 32'(got), 4);
      @(negedge clk);
      in_valid = 0;
      ok = 1;
      repeat (3) begin
         @(negedge clk);
         if (out_valid) ok = 0;
      end
      chk("bp.no_dup", 32'(ok), 1);

      // reset with 2 pairs in flight
      out_ready = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         in_valid = 1; in_a = 32'h3F800000; in_b = 32'h7FA00000;
      end
      @(negedge clk);
      in_valid = 0; reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      #1;
      chk("mid_rst.out_valid", 32'(out_valid), 0);
      chk("mid_rst.in_ready", 32'(in_ready), 1);
      chk("mid_rst.invalid", 32'(invalid), 0);
      out_ready = 1;
      ok = 1;
      repeat (4) begin
         @(negedge clk);
         if (out_valid) ok = 0;
      end
      chk("mid_rst.no_stale", 32'(ok), 1);

      // randomized traffic against scoreboard
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_a = rnd_op();
         in_b = rnd_op();
         #1;
         if (out_valid && out_ready) begin
            if (qa.size() == 0) begin
               chk("rnd.unexpected_out", 32'(out_valid), 0);
            end else begin
               chk_pair($sformatf("rnd%0d", c), qa[0], qb[0]);
               void'(qa.pop_front());
               void'(qb.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            qa.push_back(in_a);
            qb.push_back(in_b);
         end
      end
      in_valid = 0;
      for (int c = 0; c < 10 && qa.size() > 0; c++) begin
         @(negedge clk);
         in_valid = 0; out_ready = 1;
         #1;
         if (out_valid) begin
            chk_pair("drain", qa[0], qb[0]);
            void'(qa.pop_front());
            void'(qb.pop_front());
         end
      end
      chk("rnd.drained", 32'(qa.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
